ocxo_pps_discipline: RTL and testbench



---
 rtl/ocxo_pps_discipline.sv | 269 ++++++++++++++++++++++++++
 tb/tb_ocxo_pps_discipline.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ocxo_pps_discipline.sv
// OCXO disciplining against GPS 1PPS: interval measurement, proportional loop, 3-wire SPI DAC writer.
// Optional fan tachometer period measurement is enabled by defining FAN_TACH_EN.
module ocxo_pps_discipline #(
  parameter int unsigned NOMINAL  = 10000000,
  parameter int          KP       = 16,
  parameter int          MAX_ERR  = 1000,
  parameter logic [15:0] DAC_INIT = 16'h8000,
  parameter int          SPI_DIV  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        gps_1pps,
  input  logic        fan_tach,
  output logic [31:0] pps_period,
  output logic [31:0] pps_error,
  output logic        pps_valid,
  output logic        pps_lost,
  output logic [15:0] dac_value,
  output logic [23:0] fan_period,
  output logic        dac_sclk,
  output logic        dac_cs_n,
  output logic        dac_sin
);

  localparam logic [31:0]        LP_NOMINAL  = 32'(NOMINAL);
  localparam logic [31:0]        LP_TIMEOUT  = 32'(2 * NOMINAL);
  localparam logic signed [31:0] LP_MAX_ERR  = 32'(MAX_ERR);
  localparam logic signed [33:0] LP_KP       = 34'(KP);
  localparam int                 DIV_W       = (SPI_DIV > 1) ? $clog2(SPI_DIV) : 1;
  localparam logic [DIV_W-1:0]   LP_DIV_LAST = DIV_W'(SPI_DIV - 1);

  typedef enum logic [2:0] {ST_IDLE, ST_LOW, ST_HIGH, ST_HOLD, ST_GAP} spi_state_t;

  logic r_pps_s1, r_pps_s2, r_pps_s3;
  logic w_pps_edge;

  logic [31:0] r_cnt;
  logic        r_armed;
  logic [31:0] r_pps_period;
  logic [31:0] r_pps_error;
  logic        r_pps_valid;
  logic        r_pps_lost;

  logic [15:0] r_dac;
  logic        r_pending;

  logic signed [33:0] w_err34;
  logic signed [33:0] w_next34;
  logic [15:0]        w_dac_sat;
  logic               w_err_ok;
  logic               w_loop_update;

  spi_state_t       r_state, w_state_next;
  logic [DIV_W-1:0] r_div, w_div_next;
  logic [4:0]       r_bit, w_bit_next;
  logic [23:0]      r_shift, w_shift_next;
  logic             r_sclk, w_sclk_next;
  logic             r_cs_n, w_cs_n_next;
  logic             w_spi_start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pps_s1 <= 1'b0;
      r_pps_s2 <= 1'b0;
      r_pps_s3 <= 1'b0;
    end else begin
      r_pps_s1 <= gps_1pps;
      r_pps_s2 <= r_pps_s1;
      r_pps_s3 <= r_pps_s2;
    end
  end

  assign w_pps_edge = r_pps_s2 & ~r_pps_s3;

  // An edge always takes priority over the loss timeout in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt        <= 32'd0;
      r_armed      <= 1'b0;
      r_pps_period <= 32'd0;
      r_pps_error  <= 32'd0;
      r_pps_valid  <= 1'b0;
      r_pps_lost   <= 1'b1;
    end else begin
      r_pps_valid <= 1'b0;
      if (w_pps_edge) begin
        r_cnt   <= 32'd1;
        r_armed <= 1'b1;
        if (r_armed) begin
          r_pps_period <= r_cnt;
          r_pps_error  <= r_cnt - LP_NOMINAL;
          r_pps_valid  <= 1'b1;
          r_pps_lost   <= 1'b0;
        end
      end else begin
        if (r_cnt != 32'hFFFF_FFFF) begin
          r_cnt <= r_cnt + 32'd1;
        end
        if (r_armed && (r_cnt >= LP_TIMEOUT)) begin
          r_pps_lost <= 1'b1;
          r_armed    <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_err34  = {{2{r_pps_error[31]}}, r_pps_error};
    w_next34 = $signed({18'd0, r_dac}) - (w_err34 * LP_KP);
    w_err_ok = ($signed(r_pps_error) <= LP_MAX_ERR) && ($signed(r_pps_error) >= -LP_MAX_ERR);
    if (w_next34[33]) begin
      w_dac_sat = 16'h0000;
    end else if (|w_next34[32:16]) begin
      w_dac_sat = 16'hFFFF;
    end else begin
      w_dac_sat = w_next34[15:0];
    end
    w_loop_update = r_pps_valid && w_err_ok && (w_dac_sat != r_dac);
  end

  // A new value arriving in the same cycle the transmitter latches a frame must stay pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dac     <= DAC_INIT;
      r_pending <= 1'b1;
    end else if (w_loop_update) begin
      r_dac     <= w_dac_sat;
      r_pending <= 1'b1;
    end else if (w_spi_start) begin
      r_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_div   <= '0;
      r_bit   <= 5'd0;
      r_shift <= 24'd0;
      r_sclk  <= 1'b0;
      r_cs_n  <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_div   <= w_div_next;
      r_bit   <= w_bit_next;
      r_shift <= w_shift_next;
      r_sclk  <= w_sclk_next;
      r_cs_n  <= w_cs_n_next;
    end
  end

  // Data moves on the falling SCLK edge so it is stable a full half-period before the DAC samples.
  always_comb begin
    w_state_next = r_state;
    w_div_next   = r_div;
    w_bit_next   = r_bit;
    w_shift_next = r_shift;
    w_sclk_next  = r_sclk;
    w_cs_n_next  = r_cs_n;
    w_spi_start  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_pending) begin
          w_spi_start  = 1'b1;
          w_shift_next = {8'h00, r_dac};
          w_cs_n_next  = 1'b0;
          w_div_next   = '0;
          w_bit_next   = 5'd0;
          w_state_next = ST_LOW;
        end
      end
      ST_LOW: begin
        if (r_div == LP_DIV_LAST) begin
          w_sclk_next  = 1'b1;
          w_div_next   = '0;
          w_state_next = ST_HIGH;
        end else begin
          w_div_next = r_div + DIV_W'(1);
        end
      end
      ST_HIGH: begin
        if (r_div == LP_DIV_LAST) begin
          w_sclk_next = 1'b0;
          w_div_next  = '0;
          if (r_bit == 5'd23) begin
            w_state_next = ST_HOLD;
          end else begin
            w_bit_next   = r_bit + 5'd1;
            w_shift_next = {r_shift[22:0], 1'b0};
            w_state_next = ST_LOW;
          end
        end else begin
          w_div_next = r_div + DIV_W'(1);
        end
      end
      ST_HOLD: begin
        if (r_div == LP_DIV_LAST) begin
          w_cs_n_next  = 1'b1;
          w_shift_next = 24'd0;
          w_div_next   = '0;
          w_state_next = ST_GAP;
        end else begin
          w_div_next = r_div + DIV_W'(1);
        end
      end
      ST_GAP: begin
        if (r_div == LP_DIV_LAST) begin
          w_div_next   = '0;
          w_state_next = ST_IDLE;
        end else begin
          w_div_next = r_div + DIV_W'(1);
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

`ifdef FAN_TACH_EN
  logic        r_fan_s1, r_fan_s2, r_fan_s3;
  logic        w_fan_edge;
  logic        r_fan_armed;
  logic [23:0] r_fan_cnt;
  logic [23:0] r_fan_period;

  assign w_fan_edge = r_fan_s2 & ~r_fan_s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fan_s1     <= 1'b0;
      r_fan_s2     <= 1'b0;
      r_fan_s3     <= 1'b0;
      r_fan_armed  <= 1'b0;
      r_fan_cnt    <= 24'd0;
      r_fan_period <= 24'd0;
    end else begin
      r_fan_s1 <= fan_tach;
      r_fan_s2 <= r_fan_s1;
      r_fan_s3 <= r_fan_s2;
      if (w_fan_edge) begin
        r_fan_cnt   <= 24'd1;
        r_fan_armed <= 1'b1;
        if (r_fan_armed) begin
          r_fan_period <= r_fan_cnt;
        end
      end else if (r_fan_cnt != 24'hFF_FFFF) begin
        r_fan_cnt <= r_fan_cnt + 24'd1;
      end
    end
  end

  assign fan_period = r_fan_period;
`else
  logic w_fan_unused;
  assign w_fan_unused = fan_tach;
  assign fan_period   = 24'd0;
`endif

  assign pps_period = r_pps_period;
  assign pps_error  = r_pps_error;
  assign pps_valid  = r_pps_valid;
  assign pps_lost   = r_pps_lost;
  assign dac_value  = r_dac;
  assign dac_sclk   = r_sclk;
  assign dac_cs_n   = r_cs_n;
  assign dac_sin    = r_shift[23];

endmodule

// File: tb/tb_ocxo_pps_discipline.sv
// Scoreboard bench for ocxo_pps_discipline, run with a shortened NOMINAL so whole PPS intervals fit the sim.
module tb_ocxo_pps_discipline;

  localparam int          NOM      = 4000;
  localparam int          KP_P     = 16;
  localparam int          MAXE     = 1000;
  localparam logic [15:0] DAC_INIT = 16'h8000;
  localparam int          SDIV     = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        gps_1pps;
  logic        fan_tach;
  logic [31:0] pps_period;
  logic [31:0] pps_error;
  logic        pps_valid;
  logic        pps_lost;
  logic [15:0] dac_value;
  logic [23:0] fan_period;
  logic        dac_sclk;
  logic        dac_cs_n;
  logic        dac_sin;

  ocxo_pps_discipline #(
    .NOMINAL (NOM),
    .KP      (KP_P),
    .MAX_ERR (MAXE),
    .DAC_INIT(DAC_INIT),
    .SPI_DIV (SDIV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .gps_1pps  (gps_1pps),
    .fan_tach  (fan_tach),
    .pps_period(pps_period),
    .pps_error (pps_error),
    .pps_valid (pps_valid),
    .pps_lost  (pps_lost),
    .dac_value (dac_value),
    .fan_period(fan_period),
    .dac_sclk  (dac_sclk),
    .dac_cs_n  (dac_cs_n),
    .dac_sin   (dac_sin)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] per;
    logic [31:0] err;
    logic [15:0] dac;
  } pps_exp_t;

  pps_exp_t    pps_q[$];
  logic [23:0] frame_q[$];

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Hand-computed loop trajectory: interval, error, resulting control word, frame expected.
  int          iv_tab [8] = '{4000, 3990, 4020, 6000, 4000, 3000, 3000, 3900};
  int          err_tab[8] = '{0, -10, 20, 2000, 0, -1000, -1000, -100};
  logic [15:0] dac_tab[8] = '{16'h8000, 16'h80A0, 16'h7F60, 16'h7F60,
                              16'h7F60, 16'hBDE0, 16'hFC60, 16'hFFFF};
  bit          frm_tab[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  logic        dac_chk = 1'b0;
  logic [15:0] dac_exp = 16'h0;

  always @(negedge clk) begin
    pps_exp_t e;
    if (rst) begin
      dac_chk = 1'b0;
    end else begin
      if (dac_chk) begin
        chk("dac_after_update", {16'h0, dac_value}, {16'h0, dac_exp});
        dac_chk = 1'b0;
      end
      if (pps_valid) begin
        if (pps_q.size() == 0) begin
          chk("pps_valid_unexpected", {31'b0, pps_valid}, 32'd0);
        end else begin
          e = pps_q.pop_front();
          $display("pps: period=%0d error=%0d lost=%0b", pps_period, $signed(pps_error), pps_lost);
          chk("pps_period", pps_period, e.per);
          chk("pps_error", pps_error, e.err);
          chk("pps_lost_after_meas", {31'b0, pps_lost}, 32'd0);
          dac_exp = e.dac;
          dac_chk = 1'b1;
        end
      end
    end
  end

  logic        prev_sclk = 1'b0;
  logic        prev_cs   = 1'b1;
  logic [23:0] sh        = 24'h0;
  int          nb        = 0;

  always @(negedge clk) begin
    logic [23:0] ef;
    if (rst) begin
      prev_sclk = 1'b0;
      prev_cs   = 1'b1;
      nb        = 0;
    end else begin
      if (prev_cs && !dac_cs_n) begin
        nb = 0;
        sh = 24'h0;
      end
      if (!dac_cs_n && dac_sclk && !prev_sclk) begin
        sh = {sh[22:0], dac_sin};
        nb++;
      end
      if (!prev_cs && dac_cs_n) begin
        $display("spi: frame=%06h bits=%0d", sh, nb);
        chk("spi_bit_count", 32'(nb), 32'd24);
        if (frame_q.size() == 0) begin
          chk("spi_frame_unexpected", {31'b0, dac_cs_n}, 32'd0);
        end else begin
          ef = frame_q.pop_front();
          chk("spi_frame", {8'h0, sh}, {8'h0, ef});
        end
      end
      prev_sclk = dac_sclk;
      prev_cs   = dac_cs_n;
    end
  end

  // Rising edge of gps_1pps lands exactly n clocks after the previous one.
  task automatic pulse_after(input int n);
    repeat (n - 1) @(posedge clk);
    #1 gps_1pps = 1'b1;
    @(posedge clk);
    #1 gps_1pps = 1'b0;
  endtask

  task automatic issue(input int i);
    pps_exp_t e;
    e.per = 32'(iv_tab[i]);
    e.err = 32'(err_tab[i]);
    e.dac = dac_tab[i];
    pps_q.push_back(e);
    if (frm_tab[i]) frame_q.push_back({8'h00, dac_tab[i]});
    pulse_after(iv_tab[i]);
  endtask

  task automatic pps_seq();
    repeat (400) @(posedge clk);
    @(negedge clk);
    chk("lost_no_pps", {31'b0, pps_lost}, 32'd1);
    chk("valid_no_pps", {31'b0, pps_valid}, 32'd0);
    pulse_after(10);
    for (int i = 0; i < 4; i++) issue(i);
    repeat (9000) @(posedge clk);
    @(negedge clk);
    chk("lost_after_timeout", {31'b0, pps_lost}, 32'd1);
    pulse_after(50);
    for (int i = 4; i < 8; i++) issue(i);
  endtask

  task automatic fan_seq();
`ifdef FAN_TACH_EN
    repeat (100) @(posedge clk);
    #1 fan_tach = 1'b1;
    repeat (30) @(posedge clk);
    #1 fan_tach = 1'b0;
    chk("fan_first_edge_only_arms", {8'h0, fan_period}, 32'd0);
    repeat (59970) @(posedge clk);
    #1 fan_tach = 1'b1;
    repeat (30) @(posedge clk);
    #1 fan_tach = 1'b0;
    @(negedge clk);
    $display("fan: period=%0d", fan_period);
    chk("fan_period", {8'h0, fan_period}, 32'd60000);
`else
    for (int k = 0; k < 4; k++) begin
      repeat (200) @(posedge clk);
      #1 fan_tach = ~fan_tach;
    end
    @(negedge clk);
    chk("fan_period_disabled", {8'h0, fan_period}, 32'd0);
`endif
  endtask

  initial begin
    rst      = 1'b1;
    gps_1pps = 1'b0;
    fan_tach = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pps_period", pps_period, 32'd0);
    chk("rst_pps_error", pps_error, 32'd0);
    chk("rst_pps_valid", {31'b0, pps_valid}, 32'd0);
    chk("rst_pps_lost", {31'b0, pps_lost}, 32'd1);
    chk("rst_dac_value", {16'h0, dac_value}, {16'h0, DAC_INIT});
    chk("rst_fan_period", {8'h0, fan_period}, 32'd0);
    chk("rst_sclk", {31'b0, dac_sclk}, 32'd0);
    chk("rst_cs_n", {31'b0, dac_cs_n}, 32'd1);
    chk("rst_sin", {31'b0, dac_sin}, 32'd0);
    frame_q.push_back(24'h008000);
    @(posedge clk);
    #1 rst = 1'b0;
    fork
      pps_seq();
      fan_seq();
    join
    repeat (500) @(posedge clk);
    @(negedge clk);
    chk("pps_results_outstanding", 32'(pps_q.size()), 32'd0);
    chk("frames_outstanding", 32'(frame_q.size()), 32'd0);
    chk("final_dac_value", {16'h0, dac_value}, 32'h0000_FFFF);
    chk("final_cs_idle", {31'b0, dac_cs_n}, 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
